// File: rtl/neighbor_info_bank_arbiter_pkg.sv
// Shared defaults and record types for the neighbor-info bank arbiter.
package neighbor_info_bank_arbiter_pkg;

    // Default geometry of the neighbor-info memory.
    localparam int NIB_NUM_BANK   = 4;
    localparam int NIB_ROW_W      = 7;
    localparam int NIB_DATA_W     = 16;
    localparam int NIB_TAG_W      = 4;
    localparam int NIB_STARVE_MAX = 4;

    // One bank's SRAM request pins (cen/wen active low).
    typedef struct packed {
        logic                  cen;
        logic                  wen;
        logic [NIB_ROW_W-1:0]  a;
        logic [NIB_DATA_W-1:0] d;
    } bank_req_t;

    // One read response as held in the response buffer.
    typedef struct packed {
        logic [NIB_DATA_W-1:0] data;
        logic [NIB_TAG_W-1:0]  tag;
    } rsp_t;

endpackage

// File: rtl/neighbor_info_bank_arbiter_if.sv
// Request, response and SRAM bank bundle of the neighbor-info bank arbiter.
interface neighbor_info_bank_arbiter_if #(
    parameter int NUM_BANK = 4,
    parameter int ROW_W    = 7,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4
);
    localparam int ADDR_W = ROW_W + $clog2(NUM_BANK);

    logic                       wr_valid;
    logic                       wr_ready;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [ADDR_W-1:0]          rd_addr;
    logic [TAG_W-1:0]           rd_tag;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_W-1:0]          rsp_data;
    logic [TAG_W-1:0]           rsp_tag;
    logic [NUM_BANK-1:0]        bank_cen;
    logic [NUM_BANK-1:0]        bank_wen;
    logic [NUM_BANK*ROW_W-1:0]  bank_a;
    logic [NUM_BANK*DATA_W-1:0] bank_d;
    logic [NUM_BANK*DATA_W-1:0] bank_q;

    // Requesters, response consumer and SRAM macros together.
    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tag, rsp_ready, bank_q,
        input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_tag,
        input  bank_cen, bank_wen, bank_a, bank_d
    );

    // The arbiter itself.
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tag, rsp_ready, bank_q,
        output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_tag,
        output bank_cen, bank_wen, bank_a, bank_d
    );
endinterface

// File: rtl/neighbor_info_rsp_fifo.sv
// Two-entry in-order response buffer; push and pop may coincide at any fill level.
module neighbor_info_rsp_fifo
    import neighbor_info_bank_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  rsp_t       i_din,
    input  logic       i_pop,
    output rsp_t       o_dout,
    output logic [1:0] o_count
);
    rsp_t       r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    // Storage, pointers and occupancy; a push into a full buffer is only legal
    // alongside a pop, in which case it lands in the slot being vacated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Credits reserve a slot for every read in flight, so this must never fire.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && !i_pop && (r_count == 2'd2)));

endmodule

// File: rtl/neighbor_info_bank_arbiter.sv
// Shares the banked single-port neighbor-info SRAMs between a write port and a
// read port, with write-starvation protection and a credit-guarded read return.
module neighbor_info_bank_arbiter
    import neighbor_info_bank_arbiter_pkg::*;
#(
    parameter int NUM_BANK   = NIB_NUM_BANK,
    parameter int ROW_W      = NIB_ROW_W,
    parameter int DATA_W     = NIB_DATA_W,
    parameter int TAG_W      = NIB_TAG_W,
    parameter int STARVE_MAX = NIB_STARVE_MAX
) (
    input logic                         clk,
    input logic                         reset,
    neighbor_info_bank_arbiter_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANK);
    localparam int ADDR_W = ROW_W + BANK_W;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);

    logic [BANK_W-1:0] w_wr_bank;
    logic [BANK_W-1:0] w_rd_bank;
    logic [ROW_W-1:0]  w_wr_row;
    logic [ROW_W-1:0]  w_rd_row;
    logic              w_same_bank;
    logic              w_force_wr;
    logic              w_rd_elig;
    logic              w_rd_gnt;
    logic              w_wr_gnt;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [2:0]        w_used;
    rsp_t              w_push_rsp;
    rsp_t              w_head;

    logic [CNT_W-1:0]  r_starve;
    logic              r_inf_valid;
    logic [BANK_W-1:0] r_inf_bank;
    logic [TAG_W-1:0]  r_inf_tag;

    // Low address bits interleave banks; the upper bits select the row.
    assign w_wr_bank = bus.wr_addr[BANK_W-1:0];
    assign w_wr_row  = bus.wr_addr[ADDR_W-1:BANK_W];
    assign w_rd_bank = bus.rd_addr[BANK_W-1:0];
    assign w_rd_row  = bus.rd_addr[ADDR_W-1:BANK_W];

    // Slots claimed by buffered plus in-flight reads; a same-cycle pop frees one.
    assign w_pop     = (w_count != 2'd0) && bus.rsp_ready;
    assign w_used    = 3'(w_count) + 3'(r_inf_valid) - 3'(w_pop);
    assign w_rd_elig = bus.rd_valid && (w_used < 3'd2) && !reset;

    // Reads win bank conflicts until the write has lost STARVE_MAX times in a row.
    assign w_same_bank = (w_wr_bank == w_rd_bank);
    assign w_force_wr  = bus.wr_valid && w_same_bank && (r_starve == CNT_W'(STARVE_MAX));
    assign w_rd_gnt    = w_rd_elig && !w_force_wr;
    assign w_wr_gnt    = bus.wr_valid && !reset && !(w_rd_gnt && w_same_bank);

    assign bus.wr_ready = w_wr_gnt;
    assign bus.rd_ready = w_rd_gnt;

    // Count consecutive lost write arbitrations, saturating at the force point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!bus.wr_valid || w_wr_gnt) begin
            r_starve <= '0;
        end else if (r_starve != CNT_W'(STARVE_MAX)) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            bank_req_t        w_req;
            logic [ROW_W-1:0]  r_a;
            logic [DATA_W-1:0] r_d;

            // Granted bank takes the request; idle banks park on their last a/d.
            always_comb begin
                w_req.cen = 1'b1;
                w_req.wen = 1'b1;
                w_req.a   = r_a;
                w_req.d   = r_d;
                if (w_wr_gnt && (w_wr_bank == BANK_W'(gi))) begin
                    w_req.cen = 1'b0;
                    w_req.wen = 1'b0;
                    w_req.a   = w_wr_row;
                    w_req.d   = bus.wr_data;
                end else if (w_rd_gnt && (w_rd_bank == BANK_W'(gi))) begin
                    w_req.cen = 1'b0;
                    w_req.a   = w_rd_row;
                end
            end

            // Shadow of the address/data pins so they stay quiet between accesses.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a <= '0;
                    r_d <= '0;
                end else begin
                    r_a <= w_req.a;
                    r_d <= w_req.d;
                end
            end

            assign bus.bank_cen[gi]                 = w_req.cen;
            assign bus.bank_wen[gi]                 = w_req.wen;
            assign bus.bank_a[gi*ROW_W +: ROW_W]    = w_req.a;
            assign bus.bank_d[gi*DATA_W +: DATA_W]  = w_req.d;
        end
    endgenerate

    // Remember which bank answers next cycle and the tag to return with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inf_valid <= 1'b0;
            r_inf_bank  <= '0;
            r_inf_tag   <= '0;
        end else begin
            r_inf_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_inf_bank <= w_rd_bank;
                r_inf_tag  <= bus.rd_tag;
            end
        end
    end

    assign w_push_rsp.data = bus.bank_q[int'(r_inf_bank)*DATA_W +: DATA_W];
    assign w_push_rsp.tag  = r_inf_tag;

    neighbor_info_rsp_fifo u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inf_valid),
        .i_din   (w_push_rsp),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign bus.rsp_valid = (w_count != 2'd0);
    assign bus.rsp_data  = w_head.data;
    assign bus.rsp_tag   = w_head.tag;

endmodule

// File: tb/tb_neighbor_info_bank_arbiter.sv
// Scoreboard bench: directed scenarios plus randomized mixed traffic against a
// flat-memory reference model and a behavioural SRAM per bank.
module tb_neighbor_info_bank_arbiter;
    import neighbor_info_bank_arbiter_pkg::*;

    localparam int NB = NIB_NUM_BANK;
    localparam int RW = NIB_ROW_W;
    localparam int DW = NIB_DATA_W;
    localparam int TW = NIB_TAG_W;
    localparam int AW = RW + $clog2(NB);

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        bit            known;
        int            cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    neighbor_info_bank_arbiter_if #(.NUM_BANK(NB), .ROW_W(RW), .DATA_W(DW), .TAG_W(TW)) bus ();

    neighbor_info_bank_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAMs with registered read data.
    logic [DW-1:0]    sram [NB][1<<RW];
    logic [NB*DW-1:0] q_reg;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!bus.bank_cen[b]) begin
                if (!bus.bank_wen[b])
                    sram[b][bus.bank_a[b*RW +: RW]] <= bus.bank_d[b*DW +: DW];
                else
                    q_reg[b*DW +: DW] <= sram[b][bus.bank_a[b*RW +: RW]];
            end
        end
    end
    assign bus.bank_q = q_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: one flat memory indexed by global address.
    logic [DW-1:0] ref_mem [1<<AW];
    bit            ref_known [1<<AW];
    exp_t          exp_q [$];
    exp_t          e;

    // Monitor: retire responses against the queue, then record this cycle's grants.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
                    if (e.known) check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check("rsp_latency", 32'((cyc - e.cyc) >= 2), 32'd1);
                    $display("rsp tag=%0h data=%04h cyc=%0d", bus.rsp_tag, bus.rsp_data, cyc);
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                ref_mem[bus.wr_addr]   = bus.wr_data;
                ref_known[bus.wr_addr] = 1'b1;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                exp_q.push_back('{data: ref_mem[bus.rd_addr], tag: bus.rd_tag,
                                  known: ref_known[bus.rd_addr], cyc: cyc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    bit        wr_pend, rd_pend;
    int        n_acc, idx;
    logic [AW-1:0] last_wr;

    initial begin
        reset         = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = '0;
        bus.rd_tag    = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with requests pending.
        @(negedge clk);
        check("rst_cen", 32'(bus.bank_cen), 32'hF);
        check("rst_wen", 32'(bus.bank_wen), 32'hF);
        check("rst_a", 32'(bus.bank_a), 32'd0);
        check("rst_d", 32'(bus.bank_d[31:0]), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
        tick();
        reset = 1'b0;
        idle(2);

        // Write 0xBEEF to 0x05 then read it back with tag 3.
        bus.wr_valid = 1'b1; bus.wr_addr = 9'h005; bus.wr_data = 16'hBEEF;
        @(negedge clk);
        $display("wr addr=005 data=BEEF");
        check("t1_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("t1_wr_cen", 32'(bus.bank_cen), 32'hD);
        check("t1_wr_wen", 32'(bus.bank_wen), 32'hD);
        check("t1_wr_row", 32'(bus.bank_a[13:7]), 32'd1);
        check("t1_wr_d", 32'(bus.bank_d[31:16]), 32'hBEEF);
        tick();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 9'h005; bus.rd_tag = 4'd3;
        @(negedge clk);
        $display("rd addr=005 tag=3");
        check("t1_rd_ready", 32'(bus.rd_ready), 32'd1);
        check("t1_rd_cen", 32'(bus.bank_cen), 32'hD);
        check("t1_rd_wen", 32'(bus.bank_wen), 32'hF);
        tick();
        bus.rd_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1_valid", 32'(bus.rsp_valid), 32'd0);
        check("t1_hold_a", 32'(bus.bank_a[13:7]), 32'd1);
        check("t1_hold_d", 32'(bus.bank_d[31:16]), 32'hBEEF);
        check("t1_idle_cen", 32'(bus.bank_cen), 32'hF);
        @(negedge clk);
        check("t1_lat2_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_lat2_data", 32'(bus.rsp_data), 32'hBEEF);
        check("t1_lat2_tag", 32'(bus.rsp_tag), 32'd3);
        idle(2);

        // Write bank 0 and read bank 1 together.
        bus.wr_valid = 1'b1; bus.wr_addr = 9'h004; bus.wr_data = 16'h1234;
        bus.rd_valid = 1'b1; bus.rd_addr = 9'h001; bus.rd_tag = 4'd5;
        @(negedge clk);
        $display("wr addr=004 + rd addr=001");
        check("t2_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("t2_rd_ready", 32'(bus.rd_ready), 32'd1);
        check("t2_cen", 32'(bus.bank_cen), 32'hC);
        check("t2_wen0", 32'(bus.bank_wen[0]), 32'd0);
        check("t2_wen1", 32'(bus.bank_wen[1]), 32'd1);
        tick();
        idle(4);

        // Continuous conflict on bank 2: write wins on cycles 5 and 10 only.
        n_acc = 0;
        for (int k = 1; k <= 10; k++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 9'(10*4 + 2); bus.wr_data = 16'(16'hA000 + n_acc);
            bus.rd_valid = 1'b1; bus.rd_addr = 9'(k*4 + 2);  bus.rd_tag = 4'(k);
            @(negedge clk);
            $display("conflict cycle %0d wr_ready=%0d rd_ready=%0d", k, bus.wr_ready, bus.rd_ready);
            check("t3_wr_ready", 32'(bus.wr_ready), 32'((k == 5) || (k == 10)));
            check("t3_rd_ready", 32'(bus.rd_ready), 32'(!((k == 5) || (k == 10))));
            if (bus.wr_ready) n_acc++;
            tick();
        end
        idle(4);

        // Backpressure: only two reads fit, a pop frees a credit the same cycle.
        bus.rsp_ready = 1'b0;
        n_acc = 0; idx = 0;
        for (int k = 0; k < 6; k++) begin
            bus.rd_valid = (idx < 4); bus.rd_addr = 9'(idx*4 + 3); bus.rd_tag = 4'(8 + idx);
            @(negedge clk);
            if (bus.rd_valid && bus.rd_ready) begin n_acc++; idx++; end
            tick();
        end
        check("t4_accepted", 32'(n_acc), 32'd2);
        check("t4_stall_ready", 32'(bus.rd_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_pop_credit", 32'(bus.rd_ready), 32'd1);
        if (bus.rd_valid && bus.rd_ready) idx++;
        tick();
        for (int k = 0; (k < 20) && (idx < 4); k++) begin
            bus.rd_valid = 1'b1; bus.rd_addr = 9'(idx*4 + 3); bus.rd_tag = 4'(8 + idx);
            @(negedge clk);
            if (bus.rd_ready) idx++;
            tick();
        end
        check("t4_all_issued", 32'(idx), 32'd4);
        idle(6);

        // Reset with one response buffered and one read in flight.
        bus.rsp_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 9'h005; bus.rd_tag = 4'd1;
        @(negedge clk);
        check("t5_rd_a", 32'(bus.rd_ready), 32'd1);
        tick();
        bus.rd_addr = 9'h004; bus.rd_tag = 4'd2;
        @(negedge clk);
        check("t5_rd_b", 32'(bus.rd_ready), 32'd1);
        tick();
        check("t5_pre_buf", 32'(bus.rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_cen", 32'(bus.bank_cen), 32'hF);
        check("t5_rd_ready", 32'(bus.rd_ready), 32'd0);
        check("t5_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        tick();
        reset = 1'b0;
        idle(2);
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            bus.rd_valid = 1'b1; bus.rd_addr = (k == 0) ? 9'h005 : 9'h004; bus.rd_tag = 4'(12 + k);
            @(negedge clk);
            if (bus.rd_ready) n_acc++;
            if (n_acc >= 2) bus.rd_valid = 1'b0;
            tick();
            if (n_acc >= 2) break;
        end
        bus.rd_valid = 1'b0;
        check("t5_credit2", 32'(n_acc), 32'd2);
        bus.rsp_ready = 1'b1;
        idle(6);

        // Randomized mixed traffic.
        wr_pend = 1'b0; rd_pend = 1'b0; last_wr = '0;
        for (int k = 0; k < 10000; k++) begin
            if (!wr_pend && ($urandom_range(0, 99) < 40)) begin
                wr_pend = 1'b1;
                bus.wr_addr = 9'($urandom_range(0, 63));
                bus.wr_data = 16'($urandom);
                last_wr = bus.wr_addr;
            end
            if (!rd_pend && ($urandom_range(0, 99) < 50)) begin
                rd_pend = 1'b1;
                bus.rd_addr = ($urandom_range(0, 3) == 0) ? last_wr : 9'($urandom_range(0, 63));
                bus.rd_tag  = 4'($urandom);
            end
            bus.wr_valid  = wr_pend;
            bus.rd_valid  = rd_pend;
            bus.rsp_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            if (wr_pend && bus.wr_ready) wr_pend = 1'b0;
            if (rd_pend && bus.rd_ready) rd_pend = 1'b0;
            tick();
        end
        bus.rsp_ready = 1'b1;
        idle(20);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/neighbor_info_bank_arbiter.md
Name: neighbor_info_bank_arbiter

Overview:
- Shares the banked single-port neighbor-info SRAMs between two requesters:
  - a write port, fed by the bus load path;
  - a read port, fed by the neighbor-info controller.
- Decodes global addresses into bank and row and drives every bank's CEN/WEN/A/D.
- Arbitrates same-bank conflicts with write-starvation protection.
- Returns read data through a credit-controlled 2-entry response buffer, so downstream backpressure never loses SRAM output.

Parameters:
- NUM_BANK, 4, number of SRAM banks (power of 2).
- ROW_W, 7, row address width per bank (depth 128).
- DATA_W, 16, SRAM word width.
- TAG_W, 4, read tag carried to the response.
- STARVE_MAX, 4, consecutive lost write arbitrations before the write is forced.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ROW_W+log2(NUM_BANK)  global write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  ROW_W+log2(NUM_BANK)  global read address.
- rd_tag  in  TAG_W  read tag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  downstream consumes the response.
- rsp_data  out  DATA_W  read data.
- rsp_tag  out  TAG_W  tag of the response.
- bank_cen  out  NUM_BANK  per-bank chip enable, active low.
- bank_wen  out  NUM_BANK  per-bank write enable, active low.
- bank_a  out  NUM_BANK*ROW_W  per-bank row address.
- bank_d  out  NUM_BANK*DATA_W  per-bank write data.
- bank_q  in  NUM_BANK*DATA_W  per-bank read data.

Behaviour:
- Address decode:
  - bank = addr[log2(NUM_BANK)-1:0]; row = addr[upper ROW_W bits].
  - Unsigned, no wrap checks; every address maps to a bank.
- Credits:
  - credit = 2 - buf_count - inflight, where inflight is 0 or 1.
  - A read is eligible only when credit > 0, counting any pop in the same cycle as freeing a slot.
- Arbitration (combinational, each cycle):
  - Different banks: a read and a write grant together.
  - Same bank: the read wins unless starve_cnt == STARVE_MAX, in which case the write wins and the read stalls.
  - Write with no read, or with an ineligible read: the write grants.
- starve_cnt:
  - Increments when a write is valid and loses.
  - Clears on a write grant or when wr_valid is low.
  - Saturates at STARVE_MAX.
- Handshakes:
  - wr_ready and rd_ready are the grant signals.
  - Requesters hold valid, addr and data stable until ready.
  - ready never depends on rsp_ready, other than through the same-cycle credit release.
- Bank drive:
  - Granted bank: cen=0; wen=0 for a write, 1 for a read; a=row; d=wr_data on a write.
  - Ungranted banks: cen=1, wen=1; a and d hold their last values (registered shadows).
- Read pipeline:
  - Read granted in cycle T.
  - Cycle T+1: inflight register holds {valid, bank, tag}; bank_q[bank] is captured into the response buffer at the end of T+1.
  - rsp_valid is asserted in T+2 at the earliest; read latency is 2 cycles.
- Response buffer:
  - 2-entry FIFO, in order; rsp_* shows the head.
  - Simultaneous push and pop is allowed at any occupancy.
  - Overflow is impossible by credit construction; flag it with an assertion.
- Write-then-read to the same address in consecutive cycles returns the new data (SRAM write-through order is preserved).
- Reset, asserted asynchronously at any time including mid-transaction:
  - bank_cen=all 1, bank_wen=all 1, bank_a=0, bank_d=0.
  - rsp_valid=0, rsp_data=0, rsp_tag=0.
  - buffer empty, inflight=0, starve_cnt=0.
  - wr_ready=0 and rd_ready=0 while reset is high.
  - Any in-flight read is dropped.

Decomposition:
- Shared package gets: NUM_BANK, ROW_W and DATA_W defaults (matching `num_bank_neighbor_info and `Neighbor_info_bandwidth), a bank_req struct {cen, wen, a, d}, and a rsp struct {data, tag}.
- One natural sub-module: neighbor_info_rsp_fifo, a 2-entry synchronous FIFO with count output.
- Arbitration and decode stay in the top level.

Test Plan:
- Write 0xBEEF to addr 0x05 (bank 1, row 1), then read addr 0x05 with tag 3 → bank_cen[1] low both cycles; rsp_valid 2 cycles after the read grant with data 0xBEEF, tag 3.
- Write to addr 0x04 and read addr 0x01 in the same cycle → both ready=1; bank_cen=4'b1100; bank_wen[0]=0, bank_wen[1]=1.
- Write and read both target bank 2 continuously for 10 cycles → write grants exactly on cycles 5 and 10 (starve_cnt reaches 4); reads granted on the other cycles.
- rsp_ready held low while 4 reads are issued back to back → exactly 2 reads accepted, rd_ready=0 afterwards; release rsp_ready → responses emerge in order with correct tags; the next read is accepted the same cycle as the first pop.
- Assert reset while a read is in flight and the buffer holds 1 entry → next cycle rsp_valid=0, bank_cen=4'hF; after reset, credit=2 and a fresh read returns correctly.
- Random mixed traffic against a scoreboard memory model, 10k cycles → no data or tag mismatch, no overflow assertion.
